// File: rtl/mrv1_dmem_tcm.sv
// Data-side tightly-coupled memory: one word load/store per cycle with byte enables,
// fixed-latency response pipeline, and an optional post-reset array clear.
module mrv1_dmem_tcm #(
    parameter logic [31:0] BASE_ADDR_P    = 32'h0001_0000,
    parameter int unsigned DEPTH_WORDS_P  = 1024,
    parameter int unsigned LATENCY_P      = 1,
    parameter bit          CLEAR_ON_RST_P = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dmem_req_vld_i,
    output logic        dmem_req_rdy_o,
    input  logic [31:0] dmem_req_addr_i,
    input  logic        dmem_req_w_en_i,
    input  logic [3:0]  dmem_req_w_be_i,
    input  logic [31:0] dmem_req_w_data_i,
    output logic        dmem_resp_vld_o,
    output logic [31:0] dmem_resp_r_data_o,
    output logic        dmem_resp_err_o
);

    localparam int unsigned IDX_WIDTH_LP = $clog2(DEPTH_WORDS_P);
    localparam logic [31:0] SPAN_LP      = 32'(4 * DEPTH_WORDS_P);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    typedef struct packed {
        logic        vld;
        logic        err;
        logic [31:0] data;
    } resp_t;

    state_e                  state_q, state_d;
    logic [IDX_WIDTH_LP-1:0] clr_cnt_q, clr_cnt_d;
    logic                    rdy_q;
    logic                    clr_we_c;

    logic [31:0]             off_c;
    logic                    in_range_c;
    logic                    err_c;
    logic                    acc_c;
    logic [IDX_WIDTH_LP-1:0] idx_c;
    logic [31:0]             rd_data_c;
    resp_t                   resp_c;

    logic [31:0]             mem_q [DEPTH_WORDS_P];
    resp_t                   pipe_q [LATENCY_P];

    // State register; rdy is registered from the next state so it tracks READY exactly
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= CLEAR_ON_RST_P ? ST_CLEAR : ST_READY;
            clr_cnt_q <= '0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rdy_q     <= (state_d == ST_READY);
        end
    end

    // Next-state: CLEAR walks every word once, then READY is terminal
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we_c  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we_c  = 1'b1;
                clr_cnt_d = clr_cnt_q + IDX_WIDTH_LP'(1);
                if (clr_cnt_q == IDX_WIDTH_LP'(DEPTH_WORDS_P - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    // Address decode; addresses below BASE wrap to a huge offset and fail the range test
    always_comb begin
        off_c      = dmem_req_addr_i - BASE_ADDR_P;
        in_range_c = (off_c < SPAN_LP);
        idx_c      = off_c[IDX_WIDTH_LP+1:2];
        err_c      = !in_range_c || (dmem_req_addr_i[1:0] != 2'b00);
        acc_c      = dmem_req_vld_i && rdy_q;
        rd_data_c  = mem_q[idx_c];

        resp_c      = '0;
        resp_c.vld  = acc_c;
        resp_c.err  = acc_c && err_c;
        resp_c.data = (acc_c && !dmem_req_w_en_i && !err_c) ? rd_data_c : 32'h0;
    end

    // Storage array: clear writes take priority, errored stores are dropped
    always_ff @(posedge clk_i) begin
        if (clr_we_c) begin
            mem_q[clr_cnt_q] <= 32'h0;
        end else if (acc_c && dmem_req_w_en_i && !err_c) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (dmem_req_w_be_i[k]) begin
                    mem_q[idx_c][8*k +: 8] <= dmem_req_w_data_i[8*k +: 8];
                end
            end
        end
    end

    // Response pipeline; reset discards everything in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < LATENCY_P; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= resp_c;
            for (int unsigned i = 1; i < LATENCY_P; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign dmem_req_rdy_o     = rdy_q;
    assign dmem_resp_vld_o    = pipe_q[LATENCY_P-1].vld;
    assign dmem_resp_err_o    = pipe_q[LATENCY_P-1].err;
    assign dmem_resp_r_data_o = pipe_q[LATENCY_P-1].data;

endmodule

// File: tb/tb_mrv1_dmem_tcm.sv
// Directed bench for mrv1_dmem_tcm: three instances (latency 1, 3, 4) share one
// request stream; each keeps its own response log stamped with the cycle it appeared.
module tb_mrv1_dmem_tcm;

    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int unsigned DEPTH = 16;
    localparam int          NDUT  = 3;

    typedef struct {
        logic        w_en;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } req_t;

    typedef struct {
        int unsigned cyc;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        vld;
    logic [31:0] addr;
    logic        w_en;
    logic [3:0]  be;
    logic [31:0] wdata;

    logic        rdy   [NDUT];
    logic        rvld  [NDUT];
    logic [31:0] rdata [NDUT];
    logic        rerr  [NDUT];

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    req_t        reqs[$];
    int unsigned acc[$];
    rsp_t        rq[NDUT][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mrv1_dmem_tcm #(
            .BASE_ADDR_P    (BASE),
            .DEPTH_WORDS_P  (DEPTH),
            .LATENCY_P      ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
            .CLEAR_ON_RST_P (1'b1)
        ) u_dut (
            .clk_i              (clk),
            .rst_i              (rst_i),
            .dmem_req_vld_i     (vld),
            .dmem_req_rdy_o     (rdy[g]),
            .dmem_req_addr_i    (addr),
            .dmem_req_w_en_i    (w_en),
            .dmem_req_w_be_i    (be),
            .dmem_req_w_data_i  (wdata),
            .dmem_resp_vld_o    (rvld[g]),
            .dmem_resp_r_data_o (rdata[g]),
            .dmem_resp_err_o    (rerr[g])
        );
    end

    function automatic int unsigned lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
    endfunction

    // Response monitor, sampled mid-cycle
    always @(negedge clk) begin : mon
        rsp_t r;
        for (int d = 0; d < NDUT; d++) begin
            if (rvld[d] === 1'b1) begin
                r.cyc  = cyc;
                r.err  = rerr[d];
                r.data = rdata[d];
                rq[d].push_back(r);
            end
        end
    end

    task automatic add(input logic we, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] wd, input logic e, input logic [31:0] rd);
        req_t r;
        r.w_en = we; r.addr = a; r.be = b; r.wdata = wd; r.err = e; r.rdata = rd;
        reqs.push_back(r);
    endtask

    // Drives the queued requests back to back, then lets every pipeline drain
    task automatic run_batch();
        for (int d = 0; d < NDUT; d++) rq[d].delete();
        acc.delete();
        foreach (reqs[k]) begin
            int guard = 0;
            while (rdy[0] !== 1'b1 && guard < 100) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 100) begin
                n_checks++;
                $display("FAIL rdy_timeout got rdy=%b want 1 within 100 cycles", rdy[0]);
            end
            vld = 1'b1; w_en = reqs[k].w_en; addr = reqs[k].addr;
            be = reqs[k].be; wdata = reqs[k].wdata;
            acc.push_back(cyc);
            @(posedge clk); #1;
        end
        vld = 1'b0; w_en = 1'b0; be = 4'h0; wdata = 32'h0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        rst_i = 1'b1; vld = 1'b0; w_en = 1'b0; addr = 32'h0; be = 4'h0; wdata = 32'h0;
        #3;
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if ({rdy[d], rvld[d], rerr[d], rdata[d]} !== 35'h0)
                $display("FAIL reset_outputs dut%0d got rdy=%b vld=%b err=%b data=%h want all 0",
                         d, rdy[d], rvld[d], rerr[d], rdata[d]);
            else n_pass++;
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_i = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (rdy[0] !== 1'b1 && n < 100);
        n_checks++;
        if (n !== 16) $display("FAIL clear_cycles got %0d want 16", n);
        else n_pass++;

        reqs.delete();
        for (int w = 0; w < 16; w++) add(1'b0, BASE + 32'(4 * w), 4'h0, 32'h0, 1'b0, 32'h0);
        run_batch();
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (rdy[d] !== 1'b1) $display("FAIL rdy_stays dut%0d got %b want 1", d, rdy[d]);
            else n_pass++;
            n_checks++;
            if (rq[d].size() !== reqs.size())
                $display("FAIL clear_count dut%0d got %0d want %0d", d, rq[d].size(), reqs.size());
            else n_pass++;
            for (int k = 0; k < reqs.size() && k < rq[d].size(); k++) begin
                n_checks++;
                if (rq[d][k].err !== reqs[k].err || rq[d][k].data !== reqs[k].rdata ||
                    rq[d][k].cyc != acc[k] + lat_of(d))
                    $display("FAIL clear_rsp dut%0d #%0d got err=%b data=%h cyc=%0d want err=%b data=%h cyc=%0d",
                             d, k, rq[d][k].err, rq[d][k].data, rq[d][k].cyc,
                             reqs[k].err, reqs[k].rdata, acc[k] + lat_of(d));
                else n_pass++;
            end
        end
    endtask

    task automatic test_byte_merge();
        reqs.delete();
        add(1'b1, BASE + 32'd8, 4'hF,    32'hDEAD_BEEF, 1'b0, 32'h0);
        add(1'b1, BASE + 32'd8, 4'b0011, 32'h0000_55AA, 1'b0, 32'h0);
        add(1'b0, BASE + 32'd8, 4'h0,    32'h0,         1'b0, 32'hDEAD_55AA);
        add(1'b0, BASE + 32'd8, 4'h0,    32'h0,         1'b0, 32'hDEAD_55AA);
        run_batch();
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (rq[d].size() !== reqs.size())
                $display("FAIL merge_count dut%0d got %0d want %0d", d, rq[d].size(), reqs.size());
            else n_pass++;
            for (int k = 0; k < reqs.size() && k < rq[d].size(); k++) begin
                n_checks++;
                if (rq[d][k].err !== reqs[k].err || rq[d][k].data !== reqs[k].rdata ||
                    rq[d][k].cyc != acc[k] + lat_of(d))
                    $display("FAIL merge_rsp dut%0d #%0d got err=%b data=%h cyc=%0d want err=%b data=%h cyc=%0d",
                             d, k, rq[d][k].err, rq[d][k].data, rq[d][k].cyc,
                             reqs[k].err, reqs[k].rdata, acc[k] + lat_of(d));
                else n_pass++;
            end
        end
    endtask

    task automatic test_errors();
        reqs.delete();
        add(1'b1, BASE,                 4'hF, 32'h1122_3344, 1'b0, 32'h0);
        add(1'b0, BASE + 32'd64,        4'h0, 32'h0,         1'b1, 32'h0);
        add(1'b0, BASE - 32'd4,         4'h0, 32'h0,         1'b1, 32'h0);
        add(1'b1, BASE + 32'd2,         4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0);
        add(1'b0, BASE + 32'd60,        4'h0, 32'h0,         1'b0, 32'h0);
        add(1'b0, BASE,                 4'h0, 32'h0,         1'b0, 32'h1122_3344);
        add(1'b0, BASE + 32'd1,         4'h0, 32'h0,         1'b1, 32'h0);
        run_batch();
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (rq[d].size() !== reqs.size())
                $display("FAIL err_count dut%0d got %0d want %0d", d, rq[d].size(), reqs.size());
            else n_pass++;
            for (int k = 0; k < reqs.size() && k < rq[d].size(); k++) begin
                n_checks++;
                if (rq[d][k].err !== reqs[k].err || rq[d][k].data !== reqs[k].rdata ||
                    rq[d][k].cyc != acc[k] + lat_of(d))
                    $display("FAIL err_rsp dut%0d #%0d got err=%b data=%h cyc=%0d want err=%b data=%h cyc=%0d",
                             d, k, rq[d][k].err, rq[d][k].data, rq[d][k].cyc,
                             reqs[k].err, reqs[k].rdata, acc[k] + lat_of(d));
                else n_pass++;
            end
        end
    endtask

    task automatic test_be_zero();
        reqs.delete();
        add(1'b1, BASE, 4'hF, 32'h1234_5678, 1'b0, 32'h0);
        add(1'b1, BASE, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'h0);
        add(1'b0, BASE, 4'h0, 32'h0,         1'b0, 32'h1234_5678);
        run_batch();
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (rq[d].size() !== reqs.size())
                $display("FAIL bez_count dut%0d got %0d want %0d", d, rq[d].size(), reqs.size());
            else n_pass++;
            for (int k = 0; k < reqs.size() && k < rq[d].size(); k++) begin
                n_checks++;
                if (rq[d][k].err !== reqs[k].err || rq[d][k].data !== reqs[k].rdata ||
                    rq[d][k].cyc != acc[k] + lat_of(d))
                    $display("FAIL bez_rsp dut%0d #%0d got err=%b data=%h cyc=%0d want err=%b data=%h cyc=%0d",
                             d, k, rq[d][k].err, rq[d][k].data, rq[d][k].cyc,
                             reqs[k].err, reqs[k].rdata, acc[k] + lat_of(d));
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        reqs.delete();
        for (int w = 8; w < 16; w++)
            add(1'b1, BASE + 32'(4 * w), 4'hF, 32'h1111_1111 * 32'(w - 7), 1'b0, 32'h0);
        run_batch();
        reqs.delete();
        for (int w = 8; w < 16; w++)
            add(1'b0, BASE + 32'(4 * w), 4'h0, 32'h0, 1'b0, 32'h1111_1111 * 32'(w - 7));
        run_batch();
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (rq[d].size() !== 8)
                $display("FAIL b2b_count dut%0d got %0d want 8", d, rq[d].size());
            else n_pass++;
            for (int k = 0; k < reqs.size() && k < rq[d].size(); k++) begin
                n_checks++;
                if (rq[d][k].err !== 1'b0 || rq[d][k].data !== reqs[k].rdata ||
                    rq[d][k].cyc != acc[0] + lat_of(d) + 32'(k))
                    $display("FAIL b2b_rsp dut%0d #%0d got err=%b data=%h cyc=%0d want err=0 data=%h cyc=%0d",
                             d, k, rq[d][k].err, rq[d][k].data, rq[d][k].cyc,
                             reqs[k].rdata, acc[0] + lat_of(d) + 32'(k));
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_inflight();
        int n;
        for (int d = 0; d < NDUT; d++) rq[d].delete();
        for (int k = 0; k < 3; k++) begin
            vld = 1'b1; w_en = 1'b0; addr = BASE + 32'h20 + 32'(4 * k);
            @(posedge clk); #1;
        end
        vld = 1'b0;
        n_checks++;
        if (rvld[0] !== 1'b1) $display("FAIL inflight_pre got vld=%b want 1", rvld[0]);
        else n_pass++;
        #1 rst_i = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if ({rvld[d], rerr[d], rdata[d], rdy[d]} !== 35'h0)
                $display("FAIL inflight_drop dut%0d got vld=%b err=%b data=%h rdy=%b want all 0",
                         d, rvld[d], rerr[d], rdata[d], rdy[d]);
            else n_pass++;
            rq[d].delete();
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_i = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (rdy[0] !== 1'b1 && n < 100);
        n_checks++;
        if (n !== 16) $display("FAIL reclear_cycles got %0d want 16", n);
        else n_pass++;
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (rq[d].size() !== 0)
                $display("FAIL stale_rsp dut%0d got %0d responses want 0", d, rq[d].size());
            else n_pass++;
        end

        reqs.delete();
        add(1'b0, BASE + 32'h20, 4'h0, 32'h0, 1'b0, 32'h0);
        add(1'b0, BASE,          4'h0, 32'h0, 1'b0, 32'h0);
        run_batch();
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (rq[d].size() !== reqs.size())
                $display("FAIL reclear_count dut%0d got %0d want %0d", d, rq[d].size(), reqs.size());
            else n_pass++;
            for (int k = 0; k < reqs.size() && k < rq[d].size(); k++) begin
                n_checks++;
                if (rq[d][k].err !== 1'b0 || rq[d][k].data !== 32'h0 ||
                    rq[d][k].cyc != acc[k] + lat_of(d))
                    $display("FAIL reclear_rsp dut%0d #%0d got err=%b data=%h cyc=%0d want err=0 data=0 cyc=%0d",
                             d, k, rq[d][k].err, rq[d][k].data, rq[d][k].cyc, acc[k] + lat_of(d));
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_byte_merge();
        test_errors();
        test_be_zero();
        test_back_to_back();
        test_reset_inflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
